move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
- Conditions the five raw board buttons and issues single-cycle move/select commands to the cursor-move datapath and the screen FSM.
- The cursor datapath advances once per clock while a direction code is present, so it must never see a raw level. This block debounces, detects edges, arbitrates simultaneous presses and generates hold-to-repeat pulses.
- Sits between the board button pins and the game_core play logic.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples needed to accept a new button level (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: cycles from the first pulse of a held direction to its first repeat pulse.
- REPEAT_PERIOD, 15_000_000: cycles between subsequent repeat pulses.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- screen_state_i  input  3  screen state code; `GAME_PLAY enables direction commands
- button_raw_i  input  5  asynchronous raw buttons, active-high; bit0 up, bit1 down, bit2 left, bit3 right, bit4 centre
- button_o  output  5  registered command code to move/screen logic; `BUTTON_NONE (0) when idle
- busy_o  output  1  high while a button is being held (state not IDLE)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all state registers clear; button_o = `BUTTON_NONE, busy_o = 0, FSM = IDLE, debounced levels = 0, all counters = 0.
- Synchroniser: each raw bit passes through a 2-FF synchroniser.
- Debounce, per bit:
  - A counter increments while the synced level differs from the debounced level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Edge: press event = debounced 0->1, registered one cycle.
- Latency: a clean raw rising edge yields the button_o pulse exactly DEBOUNCE_CYCLES+3 clocks after the first clk edge that samples the new level.
- Arbitration: if several press events occur in the same cycle, fixed priority applies: centre > up > down > left > right. Lower-priority events that cycle are discarded; they are not queued.
- FSM:
  - IDLE: on a press event that is allowed (see gating), pulse the code for one cycle, latch the active bit and load the repeat counter with REPEAT_DELAY. Go to DELAY for directions; go to HOLD for centre.
  - DELAY: counter decrements. At 0, pulse the active code, reload with REPEAT_PERIOD, go to REPEAT.
  - REPEAT: at 0, pulse and reload with REPEAT_PERIOD; stay in REPEAT.
  - HOLD: no pulses.
  - In DELAY, REPEAT and HOLD, deasserting the active debounced bit returns to IDLE; no pulse is issued in that cycle, even if the counter reaches 0.
  - Press events of other buttons are ignored outside IDLE. A button still held on return to IDLE produces no pulse until it is released and pressed again.
- Gating:
  - Direction pulses are issued only when screen_state_i == `GAME_PLAY.
  - In IDLE, a direction press outside `GAME_PLAY is dropped and the FSM stays IDLE.
  - If screen_state_i leaves `GAME_PLAY while in DELAY or REPEAT, go to IDLE next cycle with no pulse.
  - Centre is accepted in every screen state.
- Output form: button_o is one-hot or zero, never multi-hot. Any two pulses are separated by at least one `BUTTON_NONE cycle (needs REPEAT_PERIOD >= 2).
- Counter widths: $clog2 of the respective parameter, minimum 1.
- Reset mid-hold: async clear. After release of rst_n, a still-held button is not a new press until its debounced level is seen rising from 0. Debounced levels restart at 0, so a held button reaches 1 after DEBOUNCE_CYCLES and does generate one press.

Optional Feature:
- Macro: MOVE_REPEAT_EN.
- Defined: auto-repeat exactly as above.
- Undefined: DELAY and REPEAT are not built. Directions go to HOLD like centre, giving one pulse per press, and the REPEAT_DELAY and REPEAT_PERIOD counters are omitted.

Decomposition:
- Shared definitions in parameter.v: `BUTTON_NONE/UP/DOWN/LEFT/RIGHT/CENTER one-hot codes, `GAME_PLAY / `GAME_START screen codes, FSM state codes (MS_IDLE, MS_DELAY, MS_REPEAT, MS_HOLD).
- Sub-module: button_debounce (sync + debounce + edge for one bit, parameter DEBOUNCE_CYCLES), instantiated five times.
- The FSM and arbitration stay in move_scheduler.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, screen_state_i=`GAME_PLAY unless stated):
- Right held 100 cycles with MOVE_REPEAT_EN -> button_o=`BUTTON_RIGHT single pulses at t0=7, t0+20, then every 8 cycles until release; busy_o high throughout.
- Up bounced for 2 cycles, low 5, then held -> no pulse from the bounce; one `BUTTON_UP pulse 7 cycles after the stable edge.
- Left and down asserted in the same cycle -> one `BUTTON_DOWN pulse only. Releasing both and pressing left alone -> `BUTTON_LEFT pulse.
- screen_state_i=`GAME_START, press down -> no pulse. Press centre -> `BUTTON_CENTER pulse, no repeat while held 100 cycles.
- Right held into REPEAT, then screen_state_i changes to `GAME_START -> no further pulses, FSM IDLE, busy_o=0 next cycle.
- rst_n asserted mid-REPEAT while right is held -> button_o=0 immediately. After release, exactly one `BUTTON_RIGHT pulse 7 cycles later; without MOVE_REPEAT_EN, no further pulses.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared button command codes, screen codes, FSM states and press arbitration
// for the move_scheduler front end.
package move_scheduler_pkg;

  localparam int unsigned BTN_W    = 5;
  localparam int unsigned SCREEN_W = 3;

  // One-hot command codes; bit positions match the raw button pins.
  typedef enum logic [BTN_W-1:0] {
    BUTTON_NONE   = 5'b00000,
    BUTTON_UP     = 5'b00001,
    BUTTON_DOWN   = 5'b00010,
    BUTTON_LEFT   = 5'b00100,
    BUTTON_RIGHT  = 5'b01000,
    BUTTON_CENTER = 5'b10000
  } button_e;

  typedef enum logic [SCREEN_W-1:0] {
    GAME_START = 3'd1,
    GAME_PLAY  = 3'd2
  } screen_e;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_DELAY  = 2'd1,
    MS_REPEAT = 2'd2,
    MS_HOLD   = 2'd3
  } ms_state_e;

  // Fixed priority centre > up > down > left > right; directions only when allowed.
  function automatic logic [BTN_W-1:0] arbitrate(input logic [BTN_W-1:0] press,
                                                 input logic             dir_ok);
    logic [BTN_W-1:0] sel;
    sel = BUTTON_NONE;
    if (press[4]) begin
      sel = BUTTON_CENTER;
    end else if (dir_ok) begin
      if (press[0])      sel = BUTTON_UP;
      else if (press[1]) sel = BUTTON_DOWN;
      else if (press[2]) sel = BUTTON_LEFT;
      else if (press[3]) sel = BUTTON_RIGHT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/move_scheduler_button_debounce.sv
// One button: 2-FF synchroniser, stable-count debounce and registered rising-edge event.
module move_scheduler_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_prev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      // Count consecutive samples disagreeing with the accepted level.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/move_scheduler.sv
// Button front end: debounces five buttons, arbitrates presses and issues one-cycle
// move/select commands. Auto-repeat of held directions is built only with MOVE_REPEAT_EN.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 15_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SCREEN_W-1:0] screen_state_i,
  input  logic [BTN_W-1:0]    button_raw_i,
  output logic [BTN_W-1:0]    button_o,
  output logic                busy_o
);

  // Two pulses must be separated by at least one idle cycle.
  if (REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_bad_repeat_cfg
    $error("move_scheduler: REPEAT_PERIOD must be >= 2 and REPEAT_DELAY >= 1");
  end

  logic [BTN_W-1:0] level;
  logic [BTN_W-1:0] press;
  logic [BTN_W-1:0] sel;
  logic             dir_ok;
  logic             held;

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    move_scheduler_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (button_raw_i[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  ms_state_e        state_q;
  logic [BTN_W-1:0] button_q;
  logic [BTN_W-1:0] active_q;
  logic             busy_q;

  assign dir_ok = (screen_state_i == GAME_PLAY);
  assign sel    = arbitrate(press, dir_ok);
  assign held   = |(level & active_q);

`ifdef MOVE_REPEAT_EN
  localparam int unsigned DLY_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int unsigned PER_W = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int unsigned RPT_W = (DLY_W > PER_W) ? DLY_W : PER_W;

  logic [RPT_W-1:0] rpt_cnt_q;
`endif

  // Counter is loaded with N-1 so the next pulse lands exactly N cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MS_IDLE;
      button_q  <= BUTTON_NONE;
      active_q  <= BUTTON_NONE;
      busy_q    <= 1'b0;
`ifdef MOVE_REPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      button_q <= BUTTON_NONE;
      case (state_q)
        MS_IDLE: begin
          if (sel != BUTTON_NONE) begin
            button_q <= sel;
            active_q <= sel;
            busy_q   <= 1'b1;
`ifdef MOVE_REPEAT_EN
            rpt_cnt_q <= RPT_W'(REPEAT_DELAY - 1);
            state_q   <= (sel == BUTTON_CENTER) ? MS_HOLD : MS_DELAY;
`else
            state_q  <= MS_HOLD;
`endif
          end
        end
`ifdef MOVE_REPEAT_EN
        MS_DELAY, MS_REPEAT: begin
          if (!held || !dir_ok) begin
            state_q <= MS_IDLE;
            busy_q  <= 1'b0;
          end else if (rpt_cnt_q == '0) begin
            button_q  <= active_q;
            rpt_cnt_q <= RPT_W'(REPEAT_PERIOD - 1);
            state_q   <= MS_REPEAT;
          end else begin
            rpt_cnt_q <= rpt_cnt_q - RPT_W'(1);
          end
        end
`endif
        default: begin
          if (!held) begin
            state_q <= MS_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign button_o = button_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Randomised and directed bench for move_scheduler against an event-level reference model.
module tb_move_scheduler;
  import move_scheduler_pkg::*;

  localparam int unsigned D    = 4;
  localparam int unsigned RD   = 20;
  localparam int unsigned RP   = 8;
  localparam int unsigned MAXN = 4096;
`ifdef MOVE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] screen = GAME_PLAY;
  logic [4:0] raw = '0;
  logic [4:0] button;
  logic       busy;

  move_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .screen_state_i(screen),
    .button_raw_i  (raw),
    .button_o      (button),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Raw samples and modelled debounced levels, indexed by clock edge since reset release.
  logic [4:0] raw_h [MAXN];
  logic [4:0] deb_h [MAXN];
  int         n;
  bit         m_busy;
  logic [4:0] m_act;
  logic [4:0] m_out;
  int         m_next;
  int         pulses;
  int         first_pulse;
  logic [4:0] first_code;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [4:0] raw_at(input int i);
    return (i < 0) ? 5'd0 : raw_h[i];
  endfunction

  function automatic logic [4:0] deb_at(input int i);
    return (i < 0) ? 5'd0 : deb_h[i];
  endfunction

  // Level flips once D consecutive synchronised samples disagree with it; the FSM
  // sees levels one edge late and press events (debounced rises) two edges late.
  task automatic model_step(input logic [2:0] scr);
    logic [4:0] d, r, press, lvl, sel;
    int         order [5];
    bit         dir, play;
    order = '{4, 0, 1, 2, 3};
    play  = (scr == GAME_PLAY);
    d = deb_at(n - 1);
    for (int b = 0; b < 5; b++) begin
      bit flip;
      flip = 1'b1;
      for (int k = 0; k < int'(D); k++) begin
        r = raw_at(n - 2 - k);
        if (r[b] == d[b]) flip = 1'b0;
      end
      if (flip) d[b] = ~d[b];
    end
    deb_h[n] = d;
    press = deb_at(n - 2) & ~deb_at(n - 3);
    lvl   = deb_at(n - 1);
    m_out = '0;
    if (m_busy) begin
      dir = (m_act != BUTTON_CENTER);
      if ((lvl & m_act) == 5'd0) m_busy = 1'b0;
      else if (REP && dir && !play) m_busy = 1'b0;
      else if (REP && dir && n == m_next) begin
        m_out  = m_act;
        m_next = n + int'(RP);
      end
    end else begin
      sel = '0;
      for (int i = 0; i < 5; i++) begin
        if (sel == 5'd0 && press[order[i]] && (order[i] == 4 || play))
          sel = 5'(1) << order[i];
      end
      if (sel != 5'd0) begin
        m_out  = sel;
        m_act  = sel;
        m_busy = 1'b1;
        m_next = n + int'(RD);
      end
    end
  endtask

  task automatic step(input logic [4:0] r, input logic [2:0] scr, input string tag);
    raw    = r;
    screen = scr;
    @(posedge clk);
    raw_h[n] = r;
    model_step(scr);
    #1;
    check_eq({tag, "/button"}, 32'(button), 32'(m_out));
    check_eq({tag, "/busy"}, 32'(busy), 32'(m_busy));
    if (button != 5'd0) begin
      pulses++;
      if (first_pulse < 0) begin
        first_pulse = n;
        first_code  = button;
      end
    end
    n++;
  endtask

  task automatic apply_reset(input logic [4:0] r, input logic [2:0] scr);
    raw    = r;
    screen = scr;
    rst_n  = 1'b0;
    #1;
    check_eq("reset/button", 32'(button), 32'(BUTTON_NONE));
    check_eq("reset/busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n       = 1'b1;
    n           = 0;
    m_busy      = 1'b0;
    m_act       = '0;
    m_next      = 0;
    pulses      = 0;
    first_pulse = -1;
    first_code  = '0;
  endtask

  initial begin
    logic [4:0] rv;
    logic [2:0] sv;
    #2;

    // Right held 100 cycles.
    apply_reset('0, GAME_PLAY);
    for (int i = 0; i < 100; i++) step(BUTTON_RIGHT, GAME_PLAY, "right_hold");
    for (int i = 0; i < 20; i++) step('0, GAME_PLAY, "right_rel");
    check_eq("right_first", 32'(first_pulse), 32'd7);
    check_eq("right_count", 32'(pulses), REP ? 32'd11 : 32'd1);

    // Up bounced, then held.
    apply_reset('0, GAME_PLAY);
    for (int i = 0; i < 2; i++) step(BUTTON_UP, GAME_PLAY, "up_bounce");
    for (int i = 0; i < 5; i++) step('0, GAME_PLAY, "up_gap");
    for (int i = 0; i < 15; i++) step(BUTTON_UP, GAME_PLAY, "up_hold");
    for (int i = 0; i < 15; i++) step('0, GAME_PLAY, "up_rel");
    check_eq("up_first", 32'(first_pulse), 32'd14);
    check_eq("up_count", 32'(pulses), 32'd1);

    // Left and down together, then left alone.
    apply_reset('0, GAME_PLAY);
    for (int i = 0; i < 20; i++) step(BUTTON_LEFT | BUTTON_DOWN, GAME_PLAY, "ld_hold");
    for (int i = 0; i < 10; i++) step('0, GAME_PLAY, "ld_rel");
    for (int i = 0; i < 20; i++) step(BUTTON_LEFT, GAME_PLAY, "l_hold");
    for (int i = 0; i < 10; i++) step('0, GAME_PLAY, "l_rel");
    check_eq("ld_first_code", 32'(first_code), 32'(BUTTON_DOWN));
    check_eq("ld_count", 32'(pulses), 32'd2);

    // Outside play: direction dropped, centre accepted without repeat.
    apply_reset('0, GAME_START);
    for (int i = 0; i < 20; i++) step(BUTTON_DOWN, GAME_START, "st_down");
    for (int i = 0; i < 10; i++) step('0, GAME_START, "st_rel");
    for (int i = 0; i < 100; i++) step(BUTTON_CENTER, GAME_START, "st_centre");
    for (int i = 0; i < 10; i++) step('0, GAME_START, "st_crel");
    check_eq("st_first_code", 32'(first_code), 32'(BUTTON_CENTER));
    check_eq("st_first", 32'(first_pulse), 32'd37);
    check_eq("st_count", 32'(pulses), 32'd1);

    // Screen leaves play while right is repeating.
    apply_reset('0, GAME_PLAY);
    for (int i = 0; i < 40; i++) step(BUTTON_RIGHT, GAME_PLAY, "scr_hold");
    for (int i = 0; i < 20; i++) step(BUTTON_RIGHT, GAME_START, "scr_leave");
    for (int i = 0; i < 10; i++) step('0, GAME_START, "scr_rel");
    check_eq("scr_count", 32'(pulses), REP ? 32'd3 : 32'd1);

    // Reset asserted right after a repeat pulse while right stays held.
    apply_reset('0, GAME_PLAY);
    while (n < 36) step(BUTTON_RIGHT, GAME_PLAY, "mid_hold");
    apply_reset(BUTTON_RIGHT, GAME_PLAY);
    for (int i = 0; i < 60; i++) step(BUTTON_RIGHT, GAME_PLAY, "post_rst_hold");
    for (int i = 0; i < 15; i++) step('0, GAME_PLAY, "post_rst_rel");
    check_eq("post_rst_first", 32'(first_pulse), 32'd7);
    check_eq("post_rst_count", 32'(pulses), REP ? 32'd6 : 32'd1);

    // Random button activity with occasional screen changes.
    apply_reset('0, GAME_PLAY);
    rv = '0;
    sv = GAME_PLAY;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 29) == 0) rv[b] = ~rv[b];
      if ($urandom_range(0, 199) == 0) sv = (sv == GAME_PLAY) ? GAME_START : GAME_PLAY;
      step(rv, sv, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
